// File: rtl/mux_pkg.sv
// mux_pkg: shared constants and helpers for the pipelined N:1 multiplexer.
// The skid buffer occupancy encodings live here so that the RTL and any
// checker bound to the skid buffer share one definition.
package mux_pkg;

   localparam int MUX_DEFAULT_WIDTH = 32;
   localparam int MUX_DEFAULT_N_IN  = 4;

   // Skid buffer occupancy: head = output register, tail = skid register.
   localparam logic [1:0] MUX_OCC_EMPTY = 2'd0;
   localparam logic [1:0] MUX_OCC_ONE   = 2'd1;
   localparam logic [1:0] MUX_OCC_FULL  = 2'd2;

   // Ceiling log2, used for the derived select width.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/mux_pipe_n_skid_buf.sv
// skid_buf: two-entry valid/ready buffer whose in_ready is a plain register.
// Handshake: a beat moves across an interface on a rising clock edge where
// valid and ready are both 1; the producer keeps valid and payload steady
// until that edge, and ready never depends combinationally on valid.
// The occupancy register (occ) is the state machine; in_ready and out_valid
// are registered copies of "occ != FULL" and "occ != EMPTY".
module skid_buf
   import mux_pkg::*;
#(
   parameter int W = 34
)(
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_pld,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_pld
);

   logic [1:0]   occ;
   logic [1:0]   occ_nxt;
   logic [W-1:0] tail;
   logic         acc;
   logic         xfr;

   assign acc = in_valid & in_ready;
   assign xfr = out_valid & out_ready;

   // Next occupancy from the accept/transfer pair seen this cycle.
   always_comb begin
      occ_nxt = occ;
      case (occ)
         MUX_OCC_EMPTY: if (acc) occ_nxt = MUX_OCC_ONE;
         MUX_OCC_ONE: begin
            if (acc && !xfr)      occ_nxt = MUX_OCC_FULL;
            else if (!acc && xfr) occ_nxt = MUX_OCC_EMPTY;
         end
         MUX_OCC_FULL: if (xfr) occ_nxt = MUX_OCC_ONE;
         default: occ_nxt = MUX_OCC_EMPTY;
      endcase
   end

   // Occupancy state plus the registered handshake flags derived from it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         occ       <= MUX_OCC_EMPTY;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
      end else begin
         occ       <= occ_nxt;
         in_ready  <= (occ_nxt != MUX_OCC_FULL);
         out_valid <= (occ_nxt != MUX_OCC_EMPTY);
      end
   end

   // Head register: loaded from the input when it is (or becomes) the oldest
   // beat, or from the tail when the head drains while full.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_pld <= '0;
      end else begin
         case (occ)
            MUX_OCC_EMPTY: if (acc) out_pld <= in_pld;
            MUX_OCC_ONE:   if (acc && xfr) out_pld <= in_pld;
            MUX_OCC_FULL:  if (xfr) out_pld <= tail;
            default: ;
         endcase
      end
   end

   // Tail register: catches the beat that arrives while the head is stalled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tail <= '0;
      end else if ((occ == MUX_OCC_ONE) && acc && !xfr) begin
         tail <= in_pld;
      end
   end

endmodule

// File: rtl/mux_pipe_n.sv
// mux_pipe_n: N_IN:1 multiplexer of WIDTH-bit inputs with a registered,
// back-pressurable output. The select is applied combinationally at the
// input and the chosen data plus its select tag is stored in a skid buffer,
// so inputs may change freely once a beat has been accepted.
// A select value >= N_IN forwards a beat with zero data.
// Optional macro MUX_SEL_CHECK_EN adds the sticky sel_err output, set when
// such an out-of-range beat is accepted and cleared only by rst.
module mux_pipe_n
   import mux_pkg::*;
#(
   parameter  int WIDTH = MUX_DEFAULT_WIDTH,
   parameter  int N_IN  = MUX_DEFAULT_N_IN,
   localparam int SEL_W = clog2(N_IN)
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [SEL_W-1:0]      sel,
   input  logic [N_IN*WIDTH-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [WIDTH-1:0]      out_data,
   output logic [SEL_W-1:0]      out_sel
`ifdef MUX_SEL_CHECK_EN
   ,
   output logic                  sel_err
`endif
);

   logic [WIDTH-1:0] sel_data;

   // Pick the addressed input; an index with no matching input leaves zero.
   always_comb begin
      sel_data = '0;
      for (int k = 0; k < N_IN; k++) begin
         if (sel == SEL_W'(k)) sel_data = in_data[k*WIDTH +: WIDTH];
      end
   end

`ifdef MUX_SEL_CHECK_EN
   logic sel_oor;

   assign sel_oor = ({1'b0, sel} >= (SEL_W+1)'(N_IN));

   // Sticky out-of-range flag, raised only on an accepted beat.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sel_err <= 1'b0;
      end else if (in_valid && in_ready && sel_oor) begin
         sel_err <= 1'b1;
      end
   end
`endif

   skid_buf #(
      .W (WIDTH + SEL_W)
   ) u_skid (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_pld    ({sel, sel_data}),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_pld   ({out_sel, out_data})
   );

endmodule
